// File: rtl/pic_pkg.sv
// Shared definitions for the core's data-RAM side: RAM geometry and the
// state encoding of the RAM port arbiter.
package pic_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the data RAM between the core (priority) and a four-phase host
// requester; a bounded wait forces a single core stall so the host always completes.
module ram_port_arbiter
  import pic_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_access,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      host_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_req) begin
            if (core_access) begin
              state    <= WAIT;
              wait_cnt <= CNT_W'(1);
            end else begin
              state <= GRANT;
            end
          end
        end
        WAIT: begin
          if (!host_req) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (!core_access || wait_cnt == CNT_MAX) begin
            state <= GRANT;
          end else begin
            // Only reached below CNT_MAX, so the increment saturates naturally.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        GRANT: begin
          if (!host_we) host_rdata <= ram_rdata;
          wait_cnt <= '0;
          state    <= ACK;
        end
        ACK: begin
          // A fresh request is only honoured after req has dropped.
          if (!host_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_stall = (state == GRANT);
  assign host_ack   = (state == ACK);

  // RAM port mux; reset blocks any write, including a host write caught mid-GRANT.
  always_comb begin
    ram_we    = core_we & core_access;
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    if (state == GRANT) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
    if (rst) ram_we = 1'b0;
  end

endmodule
